// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the program-counter / fetch controller.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package pc_fetch_ctrl_pkg;

  // Next-PC selection class for the instruction in EXEC.
  typedef enum logic [1:0] {
    NEXT   = 2'd0,
    BRANCH = 2'd1,
    JAL    = 2'd2,
    JALR   = 2'd3
  } pc_mode_t;

  // Fetch/execute sequencing states.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2
  } pc_state_t;

  // Byte distance to the next sequential RV32I instruction.
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_fetch_ctrl_target_calc.sv
// Next-PC target computation for one instruction, plus alignment check.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the target is committed.
module pc_fetch_ctrl_target_calc
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALIGN_BITS = 2
) (
  input  pc_mode_t          i_mode,
  input  logic              i_alu_out,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [XLEN-1:0]   i_rs1,
  output logic [XLEN-1:0]   o_target,
  output logic              o_target_misaligned
);

  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_rel;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_jalr;

  // All sums wrap modulo 2^XLEN; JALR clears bit 0 of its sum.
  assign w_seq      = i_pc + XLEN'(PC_STEP);
  assign w_rel      = i_pc + i_imm;
  assign w_jalr_sum = i_rs1 + i_imm;
  assign w_jalr     = w_jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};

  // Select target by instruction class; ALU_out matters only for branches.
  always_comb begin
    o_target = w_seq;
    case (i_mode)
      NEXT:    o_target = w_seq;
      BRANCH:  o_target = i_alu_out ? w_rel : w_seq;
      JAL:     o_target = w_rel;
      JALR:    o_target = w_jalr;
      default: o_target = w_seq;
    endcase
  end

  assign o_target_misaligned = |o_target[ALIGN_BITS-1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// RV32I PC unit: FETCH/EXEC/TRAP sequencer, PC register and retired counter.
// Latency: new PC visible one cycle after a non-stalled EXEC; outputs are registered.
// Backpressure: i_instr_ack gates FETCH->EXEC, i_disable freezes EXEC, i_trap_clr releases TRAP.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_VEC  = 32'h0,
  parameter logic [XLEN-1:0]  TRAP_VEC   = 32'h100,
  parameter int               ALIGN_BITS = 2,
  parameter int               CNT_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_disable,
  input  logic              i_instr_ack,
  input  pc_mode_t          i_mode,
  input  logic              i_alu_out,
  input  logic [XLEN-1:0]   i_imm_val,
  input  logic [XLEN-1:0]   i_rs1_val,
  input  logic              i_trap_clr,
  output logic [XLEN-1:0]   o_pc_val,
  output logic [XLEN-1:0]   o_link_val,
  output logic              o_fetch_req,
  output logic              o_misalign,
  output logic [CNT_W-1:0]  o_instret
);

  pc_state_t         r_state;
  pc_state_t         w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic [CNT_W-1:0]  r_instret;
  logic [CNT_W-1:0]  w_instret_nxt;
  logic [XLEN-1:0]   w_target;
  logic              w_target_mis;

  pc_fetch_ctrl_target_calc #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_target_calc (
    .i_mode              (i_mode),
    .i_alu_out           (i_alu_out),
    .i_pc                (r_pc),
    .i_imm               (i_imm_val),
    .i_rs1               (i_rs1_val),
    .o_target            (w_target),
    .o_target_misaligned (w_target_mis)
  );

  // State, PC and retire counter; clr wins over everything, including a live handshake.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state   <= FETCH;
      r_pc      <= RESET_VEC;
      r_instret <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instret <= w_instret_nxt;
    end
  end

  // Next state: a misaligned target parks the faulting PC in TRAP without retiring.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_instret_nxt = r_instret;
    case (r_state)
      FETCH: begin
        if (i_instr_ack) w_state_nxt = EXEC;
      end
      EXEC: begin
        if (!i_disable) begin
          if (w_target_mis) begin
            w_state_nxt = TRAP;
          end else begin
            w_pc_nxt      = w_target;
            w_instret_nxt = r_instret + CNT_W'(1);
            w_state_nxt   = FETCH;
          end
        end
      end
      TRAP: begin
        if (i_trap_clr) begin
          w_pc_nxt    = TRAP_VEC;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  assign o_pc_val    = r_pc;
  assign o_link_val  = r_pc + XLEN'(PC_STEP);
  assign o_fetch_req = (r_state == FETCH);
  assign o_misalign  = (r_state == TRAP);
  assign o_instret   = r_instret;

endmodule
